uart_tx_sched: RTL

Transmit scheduler sharing one UART transmit path (`tx_ctl`) among `N_REQ` byte-stream requesters. Round-robin arbitration at packet granularity. Issues one byte at a time over the `tx_ctl` handshake `din`/`tx_en`/`tx_rdy`, and holds the grant until the requester marks the last byte. Sits between client logic (command responders, debug printers) and `tx_ctl`.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/uart_tx_sched.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit-side blocks.
//   BYTE_W      : width of one UART data byte.
//   tx_state_e  : states of the transmit scheduler.
//     IDLE      - no grant held; pick the next requester.
//     ISSUE     - grant held; waiting to hand a byte to tx_ctl.
//     WAIT_BUSY - byte issued; waiting for tx_ctl to report busy (or time out).
//     WAIT_DONE - waiting for tx_ctl to return to idle.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage : uart_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts at `ptr` and wraps
// modulo N_REQ; the first asserted request found wins. Shared with the RX side.
// Ports:
//   req       in  N_REQ  request vector
//   ptr       in  IDX_W  index the search starts from (must be < N_REQ)
//   grant     out N_REQ  one-hot winner (all zero when no request)
//   grant_idx out IDX_W  binary index of the winner (0 when no request)
//   any       out 1      at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      // Rotate the search origin; ptr < N_REQ so one subtraction wraps it.
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
// Shares one UART transmit path (tx_ctl) among N_REQ byte-stream requesters.
// Round-robin arbitration at packet granularity: a requester keeps the grant
// until it presents a byte flagged `last`. Bytes are handed to tx_ctl one at a
// time over the din / tx_en / tx_rdy handshake.
//
// Optional feature (macro UART_TX_SCHED_BURST_EN): the grant is also released
// after MAX_BURST bytes; the owner resumes its packet on its next grant.
//
// Ports:
//   clk        in  1              system clock, rising edge
//   rst        in  1              asynchronous reset, active low
//   req_valid  in  N_REQ          lane i presents a byte
//   req_data   in  8*N_REQ        lane i byte = bits [8i+7:8i]
//   req_last   in  N_REQ          lane i byte ends its packet
//   req_ready  out N_REQ          one-cycle pulse: lane i byte consumed
//   tx_din     out 8              byte to tx_ctl (held between issues)
//   tx_en      out 1              one-cycle issue strobe to tx_ctl
//   tx_rdy     in  1              tx_ctl idle (1) / transmitting (0)
//   grant_id   out clog2(N_REQ)   current owner, valid while busy
//   busy       out 1              a packet grant is held
// -----------------------------------------------------------------------------
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ACK_TIMEOUT = 8
`ifdef UART_TX_SCHED_BURST_EN
  ,
  parameter int MAX_BURST   = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [BYTE_W*N_REQ-1:0]  req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [BYTE_W-1:0]        tx_din,
  output logic                     tx_en,
  input  logic                     tx_rdy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  tx_state_e         state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [N_REQ-1:0]  gnt_oh_q;   // one-hot copy of grant_id for lane muxing
  logic              last_q;
  logic [TO_W-1:0]   to_cnt;

  logic [N_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;

  logic [BYTE_W-1:0] lane_byte;
  logic              lane_valid;
  logic              lane_last;
  logic              issue_fire;
  logic              release_grant;
  logic [IDX_W-1:0]  next_ptr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Select the granted lane through the registered one-hot grant.
  always_comb begin
    lane_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_oh_q[i]) lane_byte = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  assign lane_valid = |(req_valid & gnt_oh_q);
  assign lane_last  = |(req_last  & gnt_oh_q);
  assign issue_fire = (state == ISSUE) && lane_valid && tx_rdy;
  assign next_ptr   = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef UART_TX_SCHED_BURST_EN
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  logic [BURST_W-1:0] burst_cnt;

  // Bytes issued under the current grant; restarts with every new grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      burst_cnt <= '0;
    end else if (issue_fire) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  assign release_grant = last_q || (burst_cnt == BURST_W'(MAX_BURST));
`else
  assign release_grant = last_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the data register tx_din is reset along with the control state
    // because its reset value is externally visible, not just a don't-care.
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_oh_q  <= '0;
      last_q    <= 1'b0;
      to_cnt    <= '0;
      req_ready <= '0;
      tx_din    <= '0;
      tx_en     <= 1'b0;
      grant_id  <= '0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the values registered at the previous edge regardless of order.
      tx_en     <= 1'b0;
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_id <= arb_idx;
            gnt_oh_q <= arb_grant;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // Grant stays locked to the owner even while its lane is empty.
          if (issue_fire) begin
            tx_din    <= lane_byte;
            tx_en     <= 1'b1;
            req_ready <= gnt_oh_q;
            last_q    <= lane_last;
            to_cnt    <= '0;
            state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // tx_ctl may absorb the byte into its FIFO without ever dropping
          // tx_rdy; the timeout treats such a byte as accepted.
          if (!tx_rdy || (to_cnt == TO_W'(ACK_TIMEOUT - 1))) begin
            state <= WAIT_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_rdy) begin
            if (release_grant) begin
              rr_ptr <= next_ptr;
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              state  <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : uart_tx_sched
